// File: rtl/interleaver_pkg.sv
// Shared definitions for the 802.11a interleaver datapath: RATE codes,
// coded-bits-per-symbol values, sequencer state encoding and SIGNAL length.
package interleaver_pkg;

    typedef logic [3:0] rate_t;

    localparam rate_t RATE_6  = 4'b1101;
    localparam rate_t RATE_9  = 4'b1111;
    localparam rate_t RATE_12 = 4'b0101;
    localparam rate_t RATE_18 = 4'b0111;
    localparam rate_t RATE_24 = 4'b1001;
    localparam rate_t RATE_36 = 4'b1011;
    localparam rate_t RATE_48 = 4'b0001;
    localparam rate_t RATE_54 = 4'b0011;

    localparam logic [8:0] NCBPS_BPSK  = 9'd48;
    localparam logic [8:0] NCBPS_QPSK  = 9'd96;
    localparam logic [8:0] NCBPS_16QAM = 9'd192;
    localparam logic [8:0] NCBPS_64QAM = 9'd288;

    // The SIGNAL symbol is always one BPSK rate-1/2 symbol.
    localparam logic [8:0] SIG_LEN = 9'd48;

    typedef enum logic [2:0] {
        IDLE,
        SIG,
        DATA,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/interleaver_ctrl_if.sv
// Bit-stream handshake between encoder, sequencer and interleaver.
// master = the sequencer, slave = the encoder/interleaver side.
interface interleaver_ctrl_if #(
    parameter int NSYM_W = 12
) ();
    import interleaver_pkg::*;

    logic            In_Valid;
    logic            In_Ready;
    logic            Sym_First;
    logic [NSYM_W:0] Sym_Cnt;
    logic            Il_Valid;
    logic            Il_Start;
    rate_t           Il_Rate;

    modport master (
        input  In_Valid,
        input  Il_Valid,
        output In_Ready,
        output Sym_First,
        output Sym_Cnt,
        output Il_Start,
        output Il_Rate
    );

    modport slave (
        output In_Valid,
        output Il_Valid,
        input  In_Ready,
        input  Sym_First,
        input  Sym_Cnt,
        input  Il_Start,
        input  Il_Rate
    );

endinterface

// File: rtl/ncbps_lut.sv
// RATE code to coded-bits-per-OFDM-symbol lookup. Codes with bit0 = 0 are
// not legal 802.11a rates and report valid = 0 with ncbps = 0.
module ncbps_lut
    import interleaver_pkg::*;
(
    input  rate_t      rate,
    output logic [8:0] ncbps,
    output logic       valid
);

    // Pure table decode; the modulation order is set by the RATE code.
    always_comb begin
        ncbps = '0;
        valid = 1'b0;
        case (rate)
            RATE_6,  RATE_9:  begin ncbps = NCBPS_BPSK;  valid = 1'b1; end
            RATE_12, RATE_18: begin ncbps = NCBPS_QPSK;  valid = 1'b1; end
            RATE_24, RATE_36: begin ncbps = NCBPS_16QAM; valid = 1'b1; end
            RATE_48, RATE_54: begin ncbps = NCBPS_64QAM; valid = 1'b1; end
            default:          begin ncbps = '0;          valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/interleaver_ctrl.sv
// Frame sequencer for the 802.11a interleaver: runs the SIGNAL symbol at
// 6 Mbps, then Num_Symbols DATA symbols at the frame rate, then waits for
// every interleaved bit to come back out (or gives up after DRAIN_MAX idle
// cycles) before pulsing Done.
module interleaver_ctrl
    import interleaver_pkg::*;
#(
    parameter int NSYM_W    = 12,
    parameter int CNT_W     = 21,
    parameter int DRAIN_MAX = 1024
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Frame_Start,
    input  rate_t             Data_Rate,
    input  logic [NSYM_W-1:0] Num_Symbols,
    interleaver_ctrl_if.master bus,
    output logic              Busy,
    output logic              Done,
    output logic              Timeout,
    output logic              Rate_Err
);

    localparam int IDLE_W = $clog2(DRAIN_MAX);

    state_t            state;
    rate_t             rate_lat;
    rate_t             il_rate;
    logic [NSYM_W-1:0] nsym_lat;
    logic [8:0]        ncbps_lat;
    logic [CNT_W-1:0]  total;
    logic [CNT_W-1:0]  out_cnt;
    logic [CNT_W-1:0]  out_nxt;
    logic [8:0]        bit_cnt;
    logic [8:0]        sym_len;
    logic [NSYM_W:0]   sym_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              in_ready;
    logic              il_start;
    logic              xfer;
    logic              sym_end;
    logic [8:0]        lut_ncbps;
    logic              lut_valid;

    // Decode the requested rate directly so it can be checked and the
    // expected output total computed in the same cycle as Frame_Start.
    ncbps_lut u_lut (
        .rate  (Data_Rate),
        .ncbps (lut_ncbps),
        .valid (lut_valid)
    );

    assign xfer    = bus.In_Valid & in_ready;
    assign sym_len = (state == SIG) ? SIG_LEN : ncbps_lat;
    assign sym_end = xfer && (bit_cnt == sym_len - 9'd1);
    assign out_nxt = out_cnt + CNT_W'(bus.Il_Valid);

    assign bus.In_Ready  = in_ready;
    assign bus.Il_Start  = il_start;
    assign bus.Il_Rate   = il_rate;
    assign bus.Sym_Cnt   = sym_cnt;
    assign bus.Sym_First = in_ready & (bit_cnt == 9'd0);

    // Single sequencer: state, counters and every registered output.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            rate_lat  <= RATE_6;
            il_rate   <= RATE_6;
            nsym_lat  <= '0;
            ncbps_lat <= '0;
            total     <= '0;
            out_cnt   <= '0;
            bit_cnt   <= '0;
            sym_cnt   <= '0;
            idle_cnt  <= '0;
            in_ready  <= 1'b0;
            il_start  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Timeout   <= 1'b0;
            Rate_Err  <= 1'b0;
        end else begin
            Done     <= 1'b0;
            Timeout  <= 1'b0;
            Rate_Err <= 1'b0;

            if (state != IDLE) begin
                out_cnt <= out_nxt;
            end

            case (state)
                IDLE: begin
                    if (Frame_Start) begin
                        if (lut_valid) begin
                            state     <= SIG;
                            rate_lat  <= Data_Rate;
                            nsym_lat  <= Num_Symbols;
                            ncbps_lat <= lut_ncbps;
                            total     <= CNT_W'(SIG_LEN)
                                       + CNT_W'(Num_Symbols) * CNT_W'(lut_ncbps);
                            out_cnt   <= '0;
                            bit_cnt   <= '0;
                            sym_cnt   <= '0;
                            idle_cnt  <= '0;
                            il_rate   <= RATE_6;
                            in_ready  <= 1'b1;
                            il_start  <= 1'b1;
                            Busy      <= 1'b1;
                        end else begin
                            Rate_Err <= 1'b1;
                        end
                    end
                end

                SIG, DATA: begin
                    if (xfer) begin
                        if (sym_end) begin
                            bit_cnt <= '0;
                            sym_cnt <= sym_cnt + 1'b1;
                            if (state == SIG) begin
                                il_rate <= rate_lat;
                                if (nsym_lat != '0) begin
                                    state <= DATA;
                                end else begin
                                    state    <= DRAIN;
                                    in_ready <= 1'b0;
                                end
                            end else if (sym_cnt == {1'b0, nsym_lat}) begin
                                state    <= DRAIN;
                                in_ready <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 9'd1;
                        end
                    end
                end

                DRAIN: begin
                    if (out_nxt == total) begin
                        state    <= DONE;
                        Done     <= 1'b1;
                        il_start <= 1'b0;
                    end else if (bus.Il_Valid) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_W'(DRAIN_MAX - 1)) begin
                        state    <= DONE;
                        Done     <= 1'b1;
                        Timeout  <= 1'b1;
                        il_start <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    Busy     <= 1'b0;
                    il_rate  <= RATE_6;
                    idle_cnt <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/interleaver_ctrl.md
Name: interleaver_ctrl

Overview:
Frame-level sequencer for the 802.11a Interleaver. It drives Interleaver Start/Rate and gates encoder bits into the interleaver. Each frame runs the 48-bit SIGNAL symbol at Rate 4'b1101, then Num_Symbols DATA symbols at the frame rate. It then drains until every expected interleaved bit has come out of the interleaver's Valid/y path. The block sits between the convolutional encoder/puncturer and the Interleaver in the TX chain.

Parameters:
NSYM_W, 12, width of Num_Symbols (max 4095 DATA symbols)
CNT_W, 21, width of total-bit counters (covers 48 + 4095*288)
DRAIN_MAX, 1024, max cycles in DRAIN without a Valid before timeout

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
Frame_Start  input  1  one-cycle request to begin a frame; ignored unless IDLE
Data_Rate  input  4  802.11a RATE code for DATA symbols, sampled with Frame_Start
Num_Symbols  input  NSYM_W  DATA symbol count, sampled with Frame_Start
In_Valid  input  1  encoder has a coded bit this cycle
In_Ready  output  1  controller accepts a bit this cycle (transfer = In_Valid & In_Ready)
Il_Valid  input  1  Interleaver Valid output
Il_Start  output  1  Interleaver Start, held high for the whole frame
Il_Rate  output  4  Interleaver Rate
Sym_First  output  1  accepted bit is the first bit of an OFDM symbol
Sym_Cnt  output  NSYM_W+1  index of the current input symbol (0 = SIGNAL)
Busy  output  1  state != IDLE
Done  output  1  one-cycle pulse at frame end
Timeout  output  1  qualifies Done: drain did not complete
Rate_Err  output  1  one-cycle pulse: Frame_Start carried an invalid Data_Rate

Behaviour:
- Reset (any state, mid-frame included): next edge -> IDLE. All outputs 0 and all counters 0, except Il_Rate = 4'b1101.
- NCBPS lookup:
  - 1101 and 1111 -> 48
  - 0101 and 0111 -> 96
  - 1001 and 1011 -> 192
  - 0001 and 0011 -> 288
  - any code with bit0 = 0 is invalid.
- IDLE:
  - Frame_Start with a valid rate: latch rate and Num_Symbols, go to SIG on the next edge.
  - Frame_Start with an invalid rate: Rate_Err = 1 the next cycle, stay in IDLE.
- SIG:
  - Il_Start=1, Il_Rate=1101, In_Ready=1.
  - Bit counter counts transfers only. After the 48th transfer: Sym_Cnt=1, bit counter cleared.
  - Next state is DATA if Num_Symbols>0, else DRAIN.
  - Il_Rate changes to the latched rate on the same edge as the 48th transfer, so bit 49 goes in at the data rate.
- DATA:
  - In_Ready=1.
  - After NCBPS transfers: Sym_Cnt increments and the bit counter clears.
  - After the last transfer of symbol Num_Symbols: go to DRAIN.
- Sym_First is combinational: In_Ready & (bit counter == 0).
- DRAIN:
  - In_Ready=0, Il_Start stays 1.
  - Out counter counts Il_Valid in every non-IDLE state. Expected total = 48 + Num_Symbols*NCBPS, computed at latch time.
  - When out count reaches the total: go to DONE.
  - Idle counter clears on every Il_Valid. On reaching DRAIN_MAX it forces DONE with Timeout=1.
- DONE: lasts one cycle. Done=1, Il_Start=0, then IDLE. Timeout is valid only while Done=1.
- In_Valid=0 stalls counting; no bits are dropped or duplicated.
- Frame_Start outside IDLE has no effect. Frame_Start in the DONE cycle is ignored.
- Il_Valid while in IDLE is ignored.
- Out count exceeding the total cannot reach DRAIN; the total comparison is equality, checked every cycle.

Decomposition:
- Shared package interleaver_pkg holds:
  - the RATE code constants (RATE_6 = 4'b1101 through RATE_54 = 4'b0011)
  - the NCBPS constants (48/96/192/288)
  - the state encoding IDLE/SIG/DATA/DRAIN/DONE
  - the SIGNAL length of 48.
- One sub-module, ncbps_lut: combinational rate -> {ncbps[8:0], valid}. It is shared with other blocks of the modulator.

Test Plan:
1. Frame_Start, rate 1101, Num_Symbols=0, In_Valid=1 constantly, Il_Valid asserted 48 times -> In_Ready high exactly 48 cycles; Done one cycle after the 48th Il_Valid; Timeout=0.
2. Rate 1001 (24 Mbps), Num_Symbols=3, In_Valid=1 -> Il_Rate=1101 for transfers 1-48 and 1001 for transfers 49-624. Sym_First at transfers 1, 49, 241, 433. Sym_Cnt ends at 4; total Done after 624 Il_Valid.
3. Rate 0011, Num_Symbols=2, In_Valid toggling 1/0 -> exactly 624 transfers accepted; In_Ready drops after the 624th; no count advance on In_Valid=0 cycles.
4. Frame_Start with Data_Rate=4'b0100 -> Rate_Err pulse one cycle later; Busy stays 0; Il_Start stays 0.
5. Rate 0101, Num_Symbols=1, only 100 of 144 Il_Valid pulses supplied -> after DRAIN_MAX idle cycles, Done=1 and Timeout=1, then IDLE.
6. Reset asserted at transfer 30 of a frame; second Frame_Start issued during the frame before the reset -> second start ignored. Next edge after Reset: IDLE, all outputs 0, Il_Rate=1101. A new frame then runs cleanly from transfer 1.
